// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO helpers: depth derivation and Gray/binary conversion
package fifo_pkg;

  // Conversions work on a zero-extended 32-bit value, so any pointer width up to 32 fits.
  localparam int GRAY_W_MAX = 32;

  // Storage depth from the address width, shared by both FIFO sides.
  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave narrow values unaffected.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b = g;
    for (int s = 1; s < GRAY_W_MAX; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// rtl/sync_w2r.sv - two-flop pointer synchroniser into the local clock domain
module sync_w2r #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  // Two-stage capture of the Gray pointer; only the second stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read side: read pointer, flags, level and prefetching output stage
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE  = 8,
  parameter int ADDRSIZE  = 7,
  parameter int AE_THRESH = 2
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic [ADDRSIZE-1:0] rd_addr,
  input  logic [DATASIZE-1:0] mem_rd_data,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rd_level
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wq2;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] level_next;
  logic          pop;

  sync_w2r #(.WIDTH(PW)) u_sync_w2r (
    .clk   (rd_clk),
    .rst_n (rd_rst_n),
    .d     (wptr_gray),
    .q     (wq2)
  );

  // Pop whenever storage has data and the output register is free or being drained.
  always_comb begin
    pop        = !rempty && (!dout_valid || dout_ready);
    rbin_next  = rbin + PW'(pop);
    rgray_next = PW'(bin2gray(GRAY_W_MAX'(rbin_next)));
    wbin       = PW'(gray2bin(GRAY_W_MAX'(wq2)));
    level_next = wbin - rbin_next;
  end

  assign rd_addr = rbin[ADDRSIZE-1:0];

  // Pointer and flags are computed from the post-pop pointer, so empty asserts on the last pop.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rbin          <= '0;
      rptr_gray     <= '0;
      rempty        <= 1'b1;
      rd_level      <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rbin          <= rbin_next;
      rptr_gray     <= rgray_next;
      rempty        <= (rgray_next == wq2);
      rd_level      <= level_next;
      ralmost_empty <= (level_next <= PW'(AE_THRESH));
    end
  end

  // Output register: load on pop, otherwise drop valid once consumed; holds under backpressure.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (pop) begin
      dout       <= mem_rd_data;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rd_rst_n;
  logic [7:0] wptr_gray;
  logic [7:0] rptr_gray;
  logic [6:0] rd_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       rempty;
  logic       ralmost_empty;
  logic [7:0] rd_level;

  logic [7:0] mem [128];
  logic [7:0] wbin;
  int         wcnt;
  int         n_run  = 0;
  int         n_fail = 0;

  typedef struct {
    logic [7:0] w;
    logic       rdy;
    logic       e_empty;
    logic       e_dv;
    logic [7:0] e_dout;
    logic [7:0] e_level;
    logic       e_ae;
    logic [6:0] e_addr;
  } vec_t;

  vec_t vecs [15];

  always #5 rd_clk = ~rd_clk;

  function automatic logic [7:0] g_of(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] b_of(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [7:0] exp_data(input int k);
    return 8'(k * 3 + 1);
  endfunction

  assign wptr_gray   = g_of(wbin);
  assign mem_rd_data = mem[rd_addr];

  fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(7), .AE_THRESH(2)) dut (
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .wptr_gray     (wptr_gray),
    .rptr_gray     (rptr_gray),
    .rd_addr       (rd_addr),
    .mem_rd_data   (mem_rd_data),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rd_level      (rd_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    rd_rst_n   = 1'b0;
    wbin       = 8'd0;
    wcnt       = 0;
    dout_ready = 1'b0;
    repeat (2) step();
  endtask

  // Ideal writer: one word per cycle while the FIFO is not full.
  task automatic write_step(input int total);
    if (wcnt < total && 8'(wbin - b_of(rptr_gray)) < 8'd128) begin
      mem[wbin[6:0]] = exp_data(wcnt);
      wcnt++;
      wbin = wbin + 8'd1;
    end
  endtask

  initial begin
    vecs[0]  = '{8'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 7'd0};
    vecs[1]  = '{8'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 7'd0};
    vecs[2]  = '{8'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 7'd0};
    vecs[3]  = '{8'd1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1, 1'b1, 7'd0};
    vecs[4]  = '{8'd1, 1'b0, 1'b1, 1'b1, 8'hA5, 8'd0, 1'b1, 7'd1};
    vecs[5]  = '{8'd4, 1'b0, 1'b1, 1'b1, 8'hA5, 8'd0, 1'b1, 7'd1};
    vecs[6]  = '{8'd4, 1'b0, 1'b1, 1'b1, 8'hA5, 8'd0, 1'b1, 7'd1};
    vecs[7]  = '{8'd4, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd3, 1'b0, 7'd1};
    vecs[8]  = '{8'd4, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd3, 1'b0, 7'd1};
    vecs[9]  = '{8'd4, 1'b0, 1'b0, 1'b1, 8'hA5, 8'd3, 1'b0, 7'd1};
    vecs[10] = '{8'd4, 1'b1, 1'b0, 1'b1, 8'h11, 8'd2, 1'b1, 7'd2};
    vecs[11] = '{8'd4, 1'b1, 1'b0, 1'b1, 8'h22, 8'd1, 1'b1, 7'd3};
    vecs[12] = '{8'd4, 1'b1, 1'b1, 1'b1, 8'h33, 8'd0, 1'b1, 7'd4};
    vecs[13] = '{8'd4, 1'b1, 1'b1, 1'b0, 8'h33, 8'd0, 1'b1, 7'd4};
    vecs[14] = '{8'd4, 1'b0, 1'b1, 1'b0, 8'h33, 8'd0, 1'b1, 7'd4};

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[0] = 8'hA5; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'h44;

    // Reset values
    do_reset();
    check("rst_rempty", rempty, 1);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_rd_level", rd_level, 0);
    check("rst_almost_empty", ralmost_empty, 1);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rptr_gray", rptr_gray, 0);
    check("rst_dout", dout, 0);
    rd_rst_n = 1'b1;

    // Idle, single write, then three words under backpressure
    for (int i = 0; i < 15; i++) begin
      wbin       = vecs[i].w;
      dout_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_rempty", i), rempty, vecs[i].e_empty);
      check($sformatf("vec%0d_dout_valid", i), dout_valid, vecs[i].e_dv);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
      check($sformatf("vec%0d_rd_level", i), rd_level, vecs[i].e_level);
      check($sformatf("vec%0d_almost_empty", i), ralmost_empty, vecs[i].e_ae);
      check($sformatf("vec%0d_rd_addr", i), rd_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_rptr_gray", i), rptr_gray, g_of({1'b0, vecs[i].e_addr}));
    end

    // Level and almost-empty: five words, one prefetched into dout, then drain
    do_reset();
    rd_rst_n = 1'b1;
    mem[0] = 8'hA5; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'h44;
    wbin = 8'd5;
    repeat (4) step();
    check("lvl_level4", rd_level, 4);
    check("lvl_ae_low", ralmost_empty, 0);
    check("lvl_dout_a5", dout, 8'hA5);
    check("lvl_rempty0", rempty, 0);
    repeat (2) step();
    check("lvl_hold_level", rd_level, 4);
    check("lvl_hold_dout", dout, 8'hA5);
    dout_ready = 1'b1;
    begin
      logic [7:0] e_d [5];
      logic [7:0] e_l [5];
      logic       e_a [5];
      logic       e_e [5];
      e_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      e_l = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
      e_a = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      e_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
        step();
        check($sformatf("drain%0d_dout", i), dout, e_d[i]);
        check($sformatf("drain%0d_level", i), rd_level, e_l[i]);
        check($sformatf("drain%0d_ae", i), ralmost_empty, e_a[i]);
        check($sformatf("drain%0d_rempty", i), rempty, e_e[i]);
        check($sformatf("drain%0d_valid", i), dout_valid, (i < 4) ? 1 : 0);
      end
    end

    // Streaming 300 words across the pointer wrap
    begin
      int         nrx = 0;
      int         gaps = 0;
      int         errs = 0;
      int         idle = 0;
      int         toggles = 0;
      logic       saw_wrap = 1'b0;
      logic [6:0] prev_addr = 7'd0;
      logic       prev_msb = 1'b0;
      do_reset();
      rd_rst_n   = 1'b1;
      dout_ready = 1'b1;
      for (int c = 0; c < 1000; c++) begin
        step();
        if (dout_valid) begin
          if (dout !== exp_data(nrx)) errs++;
          nrx++;
        end else if (nrx > 0 && nrx < 300) begin
          gaps++;
        end
        if (prev_addr == 7'd127 && rd_addr == 7'd0) saw_wrap = 1'b1;
        if (rptr_gray[7] !== prev_msb) toggles++;
        prev_addr = rd_addr;
        prev_msb  = rptr_gray[7];
        write_step(300);
        if (nrx >= 300) idle++;
        if (idle > 4) break;
      end
      check("stream_count", nrx, 300);
      check("stream_data_errors", errs, 0);
      check("stream_gaps", gaps, 0);
      check("stream_addr_wrap", saw_wrap, 1);
      check("stream_msb_toggles", toggles, 2);
      check("stream_final_rempty", rempty, 1);
      check("stream_final_valid", dout_valid, 0);
      check("stream_final_level", rd_level, 0);
    end

    // Asynchronous reset in the middle of a stream
    do_reset();
    rd_rst_n   = 1'b1;
    dout_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      write_step(300);
    end
    check("midrst_pre_valid", dout_valid, 1);
    #1;
    rd_rst_n = 1'b0;
    #1;
    check("midrst_valid", dout_valid, 0);
    check("midrst_rempty", rempty, 1);
    check("midrst_level", rd_level, 0);
    check("midrst_ae", ralmost_empty, 1);
    check("midrst_addr", rd_addr, 0);
    check("midrst_rptr_gray", rptr_gray, 0);
    check("midrst_dout", dout, 0);
    wbin = 8'd0;
    step();
    check("midrst_held_rempty", rempty, 1);
    rd_rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_rempty", rempty, 1);
    check("post_rst_valid", dout_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
